// File: rtl/page_cache_pkg.sv
// Shared definitions for the page cache controller: FSM encoding and datapath widths.
package page_cache_pkg;
    localparam int DATA_W = 32;
    localparam int BIT_W  = 5;
    localparam logic [BIT_W-1:0] BIT_LAST = 5'd31;
    // Word counter is wide enough for WORDS up to 256.
    localparam int CNT_W  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SHIFT = 3'd2,
        STALL = 3'd3,
        DONE  = 3'd4
    } state_e;
endpackage

// File: rtl/page_cache_ctrl_if.sv
// Bundle of control, array-side and data_register-side signals of the page cache controller.
interface page_cache_ctrl_if #(
    parameter int ADDR_W = 8
);
    // Array side: arr_req is a level held with arr_addr stable until a one-cycle arr_ack,
    // and it falls the cycle after that ack. Register side: bit_adv consumes one bit only while RE_L is high.
    logic                                 CE;
    logic                                 start;
    logic [ADDR_W-1:0]                    page_addr;
    logic                                 arr_req;
    logic [ADDR_W-1:0]                    arr_addr;
    logic                                 arr_ack;
    logic [page_cache_pkg::DATA_W-1:0]    arr_data;
    logic                                 bit_adv;
    logic [page_cache_pkg::DATA_W-1:0]    data_cache;
    logic [page_cache_pkg::BIT_W-1:0]     register_add;
    logic                                 RE_L;
    logic                                 busy;
    logic                                 done;

    modport master (
        output CE, start, page_addr, arr_ack, arr_data, bit_adv,
        input  arr_req, arr_addr, data_cache, register_add, RE_L, busy, done
    );

    modport slave (
        input  CE, start, page_addr, arr_ack, arr_data, bit_adv,
        output arr_req, arr_addr, data_cache, register_add, RE_L, busy, done
    );
endinterface

// File: rtl/page_prefetch_buf.sv
// One-word prefetch buffer; bypass forwards din straight to dout without storing it.
module page_prefetch_buf
    import page_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              take,
    input  logic              bypass,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              valid
);
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            valid  <= 1'b0;
        end else if (flush) begin
            valid  <= 1'b0;
        end else if (load && !bypass) begin
            data_q <= din;
            valid  <= 1'b1;
        end else if (take) begin
            valid  <= 1'b0;
        end
    end

    assign dout = bypass ? din : data_q;
endmodule

// File: rtl/page_cache_ctrl.sv
// Page read controller: fetches WORDS array words and presents them bit by bit,
// prefetching the next word so consecutive words shift out without a bubble.
module page_cache_ctrl
    import page_cache_pkg::*;
#(
    parameter int WORDS  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    page_cache_ctrl_if.slave  bus,
    output state_e            state_dbg
);
    state_e            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              req_q, req_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] cache_q, cache_n;
    logic [BIT_W-1:0]  bit_q, bit_n;
    logic              rel_q, rel_n;

    logic              buf_load, buf_take, buf_bypass, buf_flush, buf_valid;
    logic [DATA_W-1:0] buf_dout;

    logic acked, adv, at_last_bit, last_word;

    // An ack only counts while a request is outstanding, so acks arriving after an abort are dropped.
    assign acked       = req_q && bus.arr_ack;
    assign adv         = bus.bit_adv && rel_q;
    assign at_last_bit = (bit_q == BIT_LAST);
    assign last_word   = (cnt_q == CNT_W'(WORDS - 1));

    page_prefetch_buf u_buf (
        .clk    (clk),
        .rst    (rst),
        .load   (buf_load),
        .take   (buf_take),
        .bypass (buf_bypass),
        .flush  (buf_flush),
        .din    (bus.arr_data),
        .dout   (buf_dout),
        .valid  (buf_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cache_q <= '0;
            bit_q   <= '0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            req_q   <= req_n;
            addr_q  <= addr_n;
            cache_q <= cache_n;
            bit_q   <= bit_n;
            rel_q   <= rel_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        req_n      = req_q;
        addr_n     = addr_q;
        cache_n    = cache_q;
        bit_n      = bit_q;
        rel_n      = rel_q;
        buf_load   = 1'b0;
        buf_take   = 1'b0;
        buf_bypass = 1'b0;
        buf_flush  = 1'b0;

        if (acked) req_n = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.CE) begin
                    state_n = FETCH;
                    cnt_n   = '0;
                    addr_n  = bus.page_addr;
                    req_n   = 1'b1;
                end
            end
            FETCH: begin
                if (acked) begin
                    cache_n = bus.arr_data;
                    bit_n   = '0;
                    rel_n   = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (adv && at_last_bit) begin
                    if (last_word) begin
                        rel_n   = 1'b0;
                        state_n = DONE;
                    end else if (buf_valid || acked) begin
                        // Next word comes from the buffer, or straight off the array when it lands now.
                        buf_take   = buf_valid;
                        buf_bypass = !buf_valid;
                        cache_n    = buf_dout;
                        bit_n      = '0;
                        cnt_n      = cnt_q + 1'b1;
                    end else begin
                        rel_n   = 1'b0;
                        state_n = STALL;
                    end
                end else begin
                    if (adv)   bit_n    = bit_q + 1'b1;
                    if (acked) buf_load = 1'b1;
                end
                if (!req_q && !buf_valid && !last_word) begin
                    req_n  = 1'b1;
                    addr_n = addr_q + 1'b1;
                end
            end
            STALL: begin
                if (acked) begin
                    cache_n = bus.arr_data;
                    bit_n   = '0;
                    rel_n   = 1'b1;
                    cnt_n   = cnt_q + 1'b1;
                    state_n = SHIFT;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (state_q != IDLE && bus.CE) begin
            state_n   = IDLE;
            req_n     = 1'b0;
            rel_n     = 1'b0;
            cnt_n     = '0;
            buf_flush = 1'b1;
        end
    end

    assign bus.arr_req      = req_q;
    assign bus.arr_addr     = addr_q;
    assign bus.data_cache   = cache_q;
    assign bus.register_add = bit_q;
    assign bus.RE_L         = rel_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = (state_q == DONE);
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_page_cache_ctrl.sv
// Bench for page_cache_ctrl: three instances (WORDS=1,2,4) share one driver selected by sel.
module tb_page_cache_ctrl;
    import page_cache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        ce, start, arr_ack, bit_adv;
    logic [7:0]  page_addr;
    logic [31:0] arr_data;

    page_cache_ctrl_if #(.ADDR_W(8)) bus1 ();
    page_cache_ctrl_if #(.ADDR_W(8)) bus2 ();
    page_cache_ctrl_if #(.ADDR_W(8)) bus4 ();
    state_e st1, st2, st4;

    page_cache_ctrl #(.WORDS(1), .ADDR_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));
    page_cache_ctrl #(.WORDS(2), .ADDR_W(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .state_dbg(st2));
    page_cache_ctrl #(.WORDS(4), .ADDR_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .state_dbg(st4));

    // Unselected instances see CE high and no stimulus.
    assign bus1.CE = (sel == 1) ? ce : 1'b1;
    assign bus1.start = (sel == 1) && start;
    assign bus1.page_addr = page_addr;
    assign bus1.arr_ack = (sel == 1) && arr_ack;
    assign bus1.arr_data = arr_data;
    assign bus1.bit_adv = (sel == 1) && bit_adv;
    assign bus2.CE = (sel == 2) ? ce : 1'b1;
    assign bus2.start = (sel == 2) && start;
    assign bus2.page_addr = page_addr;
    assign bus2.arr_ack = (sel == 2) && arr_ack;
    assign bus2.arr_data = arr_data;
    assign bus2.bit_adv = (sel == 2) && bit_adv;
    assign bus4.CE = (sel == 4) ? ce : 1'b1;
    assign bus4.start = (sel == 4) && start;
    assign bus4.page_addr = page_addr;
    assign bus4.arr_ack = (sel == 4) && arr_ack;
    assign bus4.arr_data = arr_data;
    assign bus4.bit_adv = (sel == 4) && bit_adv;

    logic        m_req, m_re_l, m_busy, m_done;
    logic [7:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  m_bit;
    state_e      m_state;

    always_comb begin
        m_req = bus4.arr_req; m_re_l = bus4.RE_L; m_busy = bus4.busy; m_done = bus4.done;
        m_addr = bus4.arr_addr; m_data = bus4.data_cache; m_bit = bus4.register_add; m_state = st4;
        case (sel)
            1: begin
                m_req = bus1.arr_req; m_re_l = bus1.RE_L; m_busy = bus1.busy; m_done = bus1.done;
                m_addr = bus1.arr_addr; m_data = bus1.data_cache; m_bit = bus1.register_add; m_state = st1;
            end
            2: begin
                m_req = bus2.arr_req; m_re_l = bus2.RE_L; m_busy = bus2.busy; m_done = bus2.done;
                m_addr = bus2.arr_addr; m_data = bus2.data_cache; m_bit = bus2.register_add; m_state = st2;
            end
            default: ;
        endcase
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: word i of a page lives at (base+i) mod 256; bit n of the page
    // is presented as {register_add = n%32, data_cache = word[n/32]}.
    logic [31:0] word_q[$];
    logic [7:0]  exp_addr_q[$];
    logic [36:0] exp_q[$];

    logic [7:0]  obs_addr_q[$];
    logic [36:0] obs_q[$];
    int done_cnt, re_low_cnt, req_viol, extra_req;
    bit stall_seen, timed_out;

    task automatic model_page(input int words, input logic [7:0] base, input bit fix_first, input logic [31:0] first);
        word_q.delete(); exp_addr_q.delete(); exp_q.delete();
        for (int i = 0; i < words; i++) begin
            word_q.push_back((i == 0 && fix_first) ? first : $urandom);
            exp_addr_q.push_back(8'(base + i));
        end
        for (int n = 0; n < words * 32; n++) exp_q.push_back({5'(n % 32), word_q[n / 32]});
    endtask

    // Drives one page read on the selected instance, acting as array and data_register.
    task automatic run_page(input int words, input logic [7:0] base, input int lat_max, input int slow_idx,
                            input int slow_lat, input int adv_pct, input int abort_bit, input bit stop_on_stall);
        int req_idx, lat_left, consumed;
        bit ack_prev, active, finished;
        obs_addr_q.delete(); obs_q.delete();
        done_cnt = 0; re_low_cnt = 0; req_viol = 0; extra_req = 0; stall_seen = 0;
        req_idx = 0; lat_left = -1; consumed = 0; ack_prev = 0; active = 0; finished = 0;
        @(negedge clk);
        ce = 1'b0; page_addr = base; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_state == STALL) stall_seen = 1;
            if (m_done) begin done_cnt++; finished = 1; break; end
            if (stop_on_stall && stall_seen) begin finished = 1; break; end
            if (abort_bit >= 0 && consumed == abort_bit) begin
                ce = 1'b1; arr_ack = 1'b0; bit_adv = 1'b0; finished = 1; break;
            end
            if (m_re_l) active = 1;
            else if (active) re_low_cnt++;
            arr_ack = 1'b0;
            if (ack_prev) begin
                if (m_req) req_viol++;
                ack_prev = 0; lat_left = -1;
            end else if (m_req) begin
                if (req_idx >= words) extra_req++;
                if (lat_left < 0) lat_left = (req_idx == slow_idx) ? slow_lat : int'($urandom_range(lat_max));
                if (lat_left == 0) begin
                    obs_addr_q.push_back(m_addr);
                    arr_data = (req_idx < words) ? word_q[req_idx] : 32'hDEAD_BEEF;
                    arr_ack = 1'b1; ack_prev = 1; req_idx++;
                end else lat_left--;
            end
            bit_adv = (int'($urandom_range(99)) < adv_pct);
            if (bit_adv && m_re_l) begin obs_q.push_back({m_bit, m_data}); consumed++; end
            @(negedge clk);
        end
        timed_out = !finished;
        if (abort_bit < 0) begin
            arr_ack = 1'b0; bit_adv = 1'b0;
        end
        if (abort_bit < 0 && !stop_on_stall && finished) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (m_done) done_cnt++;
                if (m_req) extra_req++;
            end
        end
    endtask

    task automatic test_reset();
        sel = 4;
        n_cmp++; if ({m_req, m_re_l, m_busy, m_done} !== 4'b0) begin n_fail++;
            $display("FAIL reset_flags got req/rel/busy/done=%b want 0000", {m_req, m_re_l, m_busy, m_done}); end
        n_cmp++; if ({m_addr, m_data, m_bit} !== 45'b0) begin n_fail++;
            $display("FAIL reset_values got addr=%h data=%h bit=%0d want all 0", m_addr, m_data, m_bit); end
        n_cmp++; if (m_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", m_state); end
        @(negedge clk); ce = 1'b1; page_addr = 8'h55; start = 1'b1;
        @(negedge clk); start = 1'b0; ce = 1'b0;
        @(negedge clk);
        n_cmp++; if ({m_busy, m_req} !== 2'b00) begin n_fail++;
            $display("FAIL start_with_ce_high got busy/req=%b want 00", {m_busy, m_req}); end
    endtask

    task automatic test_single_word();
        int bad;
        sel = 1;
        model_page(1, 8'h10, 1, 32'h0000_9CF3);
        run_page(1, 8'h10, 3, -1, 0, 100, -1, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL single_timeout got no done want done"); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL single_done got %0d want 1", done_cnt); end
        n_cmp++; if (obs_addr_q.size() !== 1 || obs_addr_q[0] !== 8'h10) begin n_fail++;
            $display("FAIL single_addr got n=%0d first=%h want 1 x 10", obs_addr_q.size(), obs_addr_q.size() > 0 ? obs_addr_q[0] : 8'hxx); end
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL single_bits bad=%0d got_len=%0d want_len=%0d", bad, obs_q.size(), exp_q.size()); end
        n_cmp++; if (extra_req !== 0) begin n_fail++; $display("FAIL single_extra_req got %0d want 0", extra_req); end
    endtask

    task automatic test_back_to_back();
        int bad;
        sel = 4;
        model_page(4, 8'h20, 0, '0);
        run_page(4, 8'h20, 0, -1, 0, 100, -1, 0);
        n_cmp++; if (timed_out || done_cnt !== 1) begin n_fail++;
            $display("FAIL b2b_done got %0d (timeout=%0d) want 1", done_cnt, timed_out); end
        n_cmp++; if (re_low_cnt !== 0) begin n_fail++; $display("FAIL b2b_re_l_gap got %0d low cycles want 0", re_low_cnt); end
        n_cmp++; if (obs_addr_q.size() !== 4) begin n_fail++; $display("FAIL b2b_req_count got %0d want 4", obs_addr_q.size()); end
        foreach (exp_addr_q[i]) begin
            n_cmp++; if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i]) begin n_fail++;
                $display("FAIL b2b_addr[%0d] got %h want %h", i, i < obs_addr_q.size() ? obs_addr_q[i] : 8'hxx, exp_addr_q[i]); end
        end
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL b2b_bits bad=%0d got_len=%0d want_len=%0d", bad, obs_q.size(), exp_q.size()); end
        n_cmp++; if (req_viol !== 0) begin n_fail++; $display("FAIL b2b_req_fall got %0d late falls want 0", req_viol); end
    endtask

    task automatic test_stall();
        int bad;
        logic [7:0] base;
        sel = 4;
        base = 8'($urandom);
        model_page(4, base, 0, '0);
        run_page(4, base, 0, 2, 40, 100, -1, 0);
        n_cmp++; if (timed_out || done_cnt !== 1) begin n_fail++;
            $display("FAIL stall_done got %0d (timeout=%0d) want 1", done_cnt, timed_out); end
        n_cmp++; if (stall_seen !== 1'b1) begin n_fail++; $display("FAIL stall_entered got %0d want 1", stall_seen); end
        n_cmp++; if (re_low_cnt == 0) begin n_fail++; $display("FAIL stall_re_l_low got %0d low cycles want >0", re_low_cnt); end
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL stall_bits bad=%0d got_len=%0d want_len=%0d", bad, obs_q.size(), exp_q.size()); end
        n_cmp++; if (req_viol !== 0 || extra_req !== 0) begin n_fail++;
            $display("FAIL stall_req got viol=%0d extra=%0d want 0/0", req_viol, extra_req); end
    endtask

    task automatic test_addr_wrap();
        int bad;
        sel = 2;
        model_page(2, 8'hFF, 0, '0);
        run_page(2, 8'hFF, 2, -1, 0, 100, -1, 0);
        n_cmp++; if (timed_out || done_cnt !== 1) begin n_fail++;
            $display("FAIL wrap_done got %0d (timeout=%0d) want 1", done_cnt, timed_out); end
        n_cmp++; if (obs_addr_q.size() !== 2 || obs_addr_q[0] !== 8'hFF || obs_addr_q[1] !== 8'h00) begin n_fail++;
            $display("FAIL wrap_addr got n=%0d %h %h want FF 00", obs_addr_q.size(),
                     obs_addr_q.size() > 0 ? obs_addr_q[0] : 8'hxx, obs_addr_q.size() > 1 ? obs_addr_q[1] : 8'hxx); end
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL wrap_bits bad=%0d got_len=%0d want_len=%0d", bad, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_abort();
        sel = 4;
        model_page(4, 8'h40, 0, '0);
        run_page(4, 8'h40, 0, 2, 500, 100, 40, 0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL abort_reached got timeout want bit 40"); end
        @(negedge clk);
        n_cmp++; if ({m_busy, m_req, m_re_l, m_done} !== 4'b0000) begin n_fail++;
            $display("FAIL abort_idle got busy/req/rel/done=%b want 0000", {m_busy, m_req, m_re_l, m_done}); end
        n_cmp++; if (m_state !== IDLE) begin n_fail++; $display("FAIL abort_state got %0d want IDLE", m_state); end
        ce = 1'b0; arr_data = $urandom; arr_ack = 1'b1;
        @(negedge clk); arr_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if ({m_busy, m_req, m_re_l, m_done} !== 4'b0000) begin n_fail++;
                $display("FAIL abort_late_ack got busy/req/rel/done=%b want 0000", {m_busy, m_req, m_re_l, m_done}); end
            @(negedge clk);
        end
        n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        int bad;
        sel = 4;
        model_page(4, 8'h80, 0, '0);
        run_page(4, 8'h80, 0, 2, 200, 100, -1, 1);
        n_cmp++; if (stall_seen !== 1'b1) begin n_fail++; $display("FAIL rst_stall_reached got %0d want 1", stall_seen); end
        arr_ack = 1'b0; bit_adv = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({m_req, m_re_l, m_busy, m_done, m_addr, m_data, m_bit} !== 49'b0) begin n_fail++;
            $display("FAIL rst_async got req=%b rel=%b busy=%b done=%b addr=%h data=%h bit=%0d want all 0",
                     m_req, m_re_l, m_busy, m_done, m_addr, m_data, m_bit); end
        @(negedge clk); rst = 1'b0;
        model_page(4, 8'h90, 0, '0);
        run_page(4, 8'h90, 1, -1, 0, 100, -1, 0);
        n_cmp++; if (timed_out || done_cnt !== 1) begin n_fail++;
            $display("FAIL rst_restart_done got %0d (timeout=%0d) want 1", done_cnt, timed_out); end
        bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
        foreach (exp_addr_q[i]) if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i]) bad++;
        n_cmp++; if (bad !== 0) begin n_fail++;
            $display("FAIL rst_restart_data bad=%0d got_len=%0d want_len=%0d", bad, obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        int bad;
        logic [7:0] base;
        sel = 4;
        for (int it = 0; it < 6; it++) begin
            base = 8'($urandom);
            model_page(4, base, 0, '0);
            run_page(4, base, $urandom_range(6), $urandom_range(3), $urandom_range(60), $urandom_range(30, 100), -1, 0);
            n_cmp++; if (timed_out || done_cnt !== 1) begin n_fail++;
                $display("FAIL rand%0d_done got %0d (timeout=%0d) want 1", it, done_cnt, timed_out); end
            bad = (obs_q.size() != exp_q.size()) ? 1 : 0;
            foreach (exp_q[i]) if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
            foreach (exp_addr_q[i]) if (i >= obs_addr_q.size() || obs_addr_q[i] !== exp_addr_q[i]) bad++;
            n_cmp++; if (bad !== 0) begin n_fail++;
                $display("FAIL rand%0d_data bad=%0d got_len=%0d want_len=%0d", it, bad, obs_q.size(), exp_q.size()); end
            n_cmp++; if (req_viol !== 0 || extra_req !== 0) begin n_fail++;
                $display("FAIL rand%0d_req got viol=%0d extra=%0d want 0/0", it, req_viol, extra_req); end
        end
    endtask

    initial begin
        sel = 4; ce = 1'b0; start = 1'b0; arr_ack = 1'b0; bit_adv = 1'b0;
        page_addr = '0; arr_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_addr_wrap();
        test_abort();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/page_cache_ctrl.md
PAGE_CACHE_CTRL -- requirements
Module: page_cache_ctrl

Interface
REQ-001 Parameter WORDS, default 8, number of 32-bit words per page read, legal range 1..256.
REQ-002 Parameter ADDR_W, default 8, array word-address width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 CE  in  1  chip enable, active low; high aborts any operation.
REQ-006 start  in  1  one-cycle pulse, begin page read.
REQ-007 page_addr  in  ADDR_W  first array word address, sampled with start.
REQ-008 arr_req  out  1  array read request, level.
REQ-009 arr_addr  out  ADDR_W  array word address, stable while arr_req=1.
REQ-010 arr_ack  in  1  one-cycle array acknowledge; arr_data valid in that cycle.
REQ-011 arr_data  in  32  array read data.
REQ-012 bit_adv  in  1  one-cycle pulse from data_register side: current bit consumed.
REQ-013 data_cache  out  32  word presented to data_register.
REQ-014 register_add  out  5  bit index into data_cache.
REQ-015 RE_L  out  1  read latch: high while data_cache/register_add valid.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  one-cycle pulse, page fully shifted.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, SHIFT, STALL, DONE.
REQ-019 IDLE: start=1 and CE=0 -> FETCH; word_cnt=0; arr_addr=page_addr; start ignored in every other state.
REQ-020 FETCH: arr_req=1 until arr_ack; on arr_ack, data_cache<=arr_data, register_add<=0, RE_L<=1, -> SHIFT (RE_L high the cycle after ack).
REQ-021 SHIFT: each bit_adv increments register_add by 1; bit_adv without RE_L=1 ignored.
REQ-022 Prefetch: in SHIFT, when prefetch buffer empty and word_cnt+1<WORDS, arr_req=1 with arr_addr=previous+1 (mod 2^ADDR_W); arr_ack loads buffer, marks valid.
REQ-023 bit_adv at register_add=31, last word (word_cnt=WORDS-1): RE_L<=0, -> DONE.
REQ-024 bit_adv at register_add=31, buffer valid: data_cache<=buffer, register_add wraps to 0, word_cnt+1, buffer invalid, RE_L stays 1, remain SHIFT (zero-bubble).
REQ-025 bit_adv at register_add=31, buffer empty: RE_L<=0, -> STALL; STALL on arr_ack loads data_cache directly, register_add=0, RE_L<=1, -> SHIFT.
REQ-026 arr_ack coinciding with bit_adv at 31: arr_data SHALL be loaded directly to data_cache (buffer bypass).
REQ-027 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-028 CE=1 in any non-IDLE state: next cycle IDLE, arr_req=0, RE_L=0, buffer invalid, no done pulse; late arr_ack ignored.
REQ-029 At most one outstanding array request; arr_req SHALL fall the cycle after arr_ack.

Reset
REQ-030 rst=1 asynchronously forces IDLE, data_cache=0, register_add=0, RE_L=0, arr_req=0, arr_addr=0, busy=0, done=0, buffer invalid, word_cnt=0.
REQ-031 Reset mid-operation discards all state; first start after release behaves as from power-up.

Structure
REQ-032 Shared package page_cache_pkg SHALL hold state encoding, DATA_W=32, BIT_W=5, BIT_LAST=31.
REQ-033 One-word prefetch buffer SHALL be sub-module page_prefetch_buf (load, take, bypass, flush, valid).

Verification
REQ-034 WORDS=1, page_addr=8'h10, ack data 32'h0000_9CF3, 32 bit_adv -> register_add 0..31, done once, arr_addr=8'h10.
REQ-035 WORDS=4, ack 1 cycle after req, bit_adv every cycle -> RE_L never drops across words, 4 requests at 8'h20..8'h23.
REQ-036 Ack delayed 40 cycles on word 2 -> STALL entered, RE_L=0 until ack, register_add restarts at 0.
REQ-037 page_addr=8'hFF, WORDS=2 -> second arr_addr=8'h00.
REQ-038 CE=1 during SHIFT word 1 -> IDLE next cycle, arr_req=0, no done; later arr_ack no effect.
REQ-039 rst pulse mid-STALL -> all outputs at reset values immediately, next start completes normally.
